// File: rtl/sdram_read.sv
// sdram_read: single-bank SDRAM read engine issuing ACTIVE / READ bursts / PRECHARGE per arbiter grant
// Ports:
//   S_CLK, RST          clock and asynchronous active-high reset
//   rd_trig, sdram_addr load a RD_WORDS transfer starting at {row[19:8], col[7:0]}
//   read_req, read_en   arbiter request / grant
//   read_ack, read_done grant finished / whole transfer finished
//   aref_req            refresh pending, closes the grant after the current burst
//   read_cmd, read_addr registered {CKE,CS,RAS,CAS,WE} command and address
//   read_dq             SDRAM data in
//   fifo_wr_req/_data   one strobe per captured word
module sdram_read #(
    parameter int CL        = 3,
    parameter int BURST_LEN = 4,
    parameter int RD_WORDS  = 256,
    parameter int TRCD      = 2,
    parameter int TRP       = 2
) (
    input  logic        S_CLK,
    input  logic        RST,
    input  logic        rd_trig,
    input  logic [19:0] sdram_addr,
    output logic        read_req,
    input  logic        read_en,
    output logic        read_ack,
    input  logic        aref_req,
    output logic [4:0]  read_cmd,
    output logic [11:0] read_addr,
    input  logic [15:0] read_dq,
    output logic        fifo_wr_req,
    output logic [15:0] fifo_wr_data,
    output logic        read_done
);
    localparam int WAIT_N = TRP > CL + 1 ? TRP : CL + 1;
    localparam int CW     = $clog2(RD_WORDS + 1);
    localparam int VW     = CL + BURST_LEN;
    localparam logic [4:0] NOP    = 5'b10111;
    localparam logic [4:0] ACTIVE = 5'b10011;
    localparam logic [4:0] READ   = 5'b10101;
    localparam logic [4:0] PRECH  = 5'b10010;
    localparam logic [CW-1:0] WORDS = CW'(RD_WORDS);
    localparam logic [CW-1:0] BLC   = CW'(BURST_LEN);
    localparam logic [7:0] T_RCD = 8'(TRCD - 2);
    localparam logic [7:0] T_BL  = 8'(BURST_LEN - 1);
    localparam logic [7:0] T_WT  = 8'(WAIT_N - 1);

    typedef enum logic [2:0] {IDLE, ACT, RCD, RD, PRE, WT} state_t;

    state_t        state, state_n;
    logic [7:0]    tmr, tmr_n;
    logic [19:0]   ptr;
    logic [CW-1:0] cnt;
    logic [11:0]   act_row;
    logic [VW-1:0] vld;
    logic          rd_issue, close, sample;
    logic [4:0]    cmd_d;
    logic [11:0]   addr_d;

    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
        end
    end

    // A row change (including 20'hFFFFF -> 0) is detected against the row that was activated.
    always_comb begin
        close   = cnt == '0 || aref_req || ptr[19:8] != act_row;
        state_n = state;
        case (state)
            IDLE:    if (read_en && cnt != '0) state_n = ACT;
            ACT:     state_n = TRCD > 1 ? RCD : RD;
            RCD:     if (tmr == T_RCD) state_n = RD;
            RD:      if (tmr == T_BL && close) state_n = PRE;
            PRE:     state_n = WT;
            WT:      if (tmr == T_WT) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        tmr_n = (state_n != state || (state == RD && tmr == T_BL)) ? '0 : tmr + 8'd1;
    end

    // Commands are decoded from the upcoming state so they appear registered with it.
    always_comb begin
        rd_issue  = state_n == RD && (state != RD || tmr == T_BL);
        cmd_d     = state_n == ACT ? ACTIVE : rd_issue ? READ : state_n == PRE ? PRECH : NOP;
        addr_d    = state_n == ACT ? ptr[19:8] : rd_issue ? {4'b0, ptr[7:0]} :
                    state_n == PRE ? 12'h400 : 12'h000;
        read_req  = state == IDLE && cnt != '0;
        read_ack  = state == WT && tmr == T_WT;
        read_done = read_ack && cnt == '0;
        sample    = |vld[VW-1:CL];
    end

    // vld[k] marks a READ issued k edges ago; data words arrive CL+1..CL+BURST_LEN edges after it.
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            read_cmd     <= NOP;
            read_addr    <= '0;
            ptr          <= '0;
            cnt          <= '0;
            act_row      <= '0;
            vld          <= '0;
            fifo_wr_req  <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            read_cmd    <= cmd_d;
            read_addr   <= addr_d;
            vld         <= {vld[VW-2:0], rd_issue};
            fifo_wr_req <= sample;
            if (sample) fifo_wr_data <= read_dq;
            if (state_n == ACT) act_row <= ptr[19:8];
            if (rd_issue) begin
                ptr <= ptr + 20'(BURST_LEN);
                cnt <= cnt - BLC;
            end else if (rd_trig && cnt == '0) begin
                ptr <= sdram_addr;
                cnt <= WORDS;
            end
        end
    end
endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: randomized bench for sdram_read against an address-level transfer model
module tb_sdram_read;
    localparam int CL = 3, BL = 4, RDW = 8, TRCD = 2, TRP = 2;
    localparam int W = TRP > CL + 1 ? TRP : CL + 1;
    localparam logic [4:0] NOP = 5'b10111, ACTC = 5'b10011, RDC = 5'b10101, PREC = 5'b10010;

    logic        S_CLK = 0, RST = 1, rd_trig = 0, read_en = 0, aref_req = 0;
    logic [19:0] sdram_addr = 0;
    logic [15:0] read_dq = 0;
    logic        read_req, read_ack, read_done, fifo_wr_req;
    logic [4:0]  read_cmd;
    logic [11:0] read_addr;
    logic [15:0] fifo_wr_data;

    int checks = 0, failures = 0;

    sdram_read #(.CL(CL), .BURST_LEN(BL), .RD_WORDS(RDW), .TRCD(TRCD), .TRP(TRP)) dut (
        .S_CLK(S_CLK), .RST(RST), .rd_trig(rd_trig), .sdram_addr(sdram_addr),
        .read_req(read_req), .read_en(read_en), .read_ack(read_ack), .aref_req(aref_req),
        .read_cmd(read_cmd), .read_addr(read_addr), .read_dq(read_dq),
        .fifo_wr_req(fifo_wr_req), .fifo_wr_data(fifo_wr_data), .read_done(read_done)
    );

    always #5 S_CLK = ~S_CLK;

    typedef struct {int cyc; logic [4:0] cmd; logic [11:0] addr;} ev_t;
    ev_t         log_q[$];
    logic [15:0] exp_q[$];
    int          cyc = 0, acks = 0, ack_cyc = 0, reads = 0, words = 0;
    logic        ack_done = 0;
    logic [15:0] seed = 0, e;
    logic [11:0] cur_row = 0;
    logic [15:0] dq_at[64];
    bit          have[64];
    logic [19:0] m_ptr = 0;
    int          m_cnt = 0;

    function automatic logic [15:0] word(input logic [19:0] a);
        return (a[15:0] * 16'h9E37) ^ {a[19:16], 12'h5A5} ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Bus monitor plus SDRAM data model: each READ schedules its burst words from memory.
    always @(posedge S_CLK) begin
        #1;
        cyc++;
        if (read_cmd != NOP) log_q.push_back('{cyc, read_cmd, read_addr});
        if (read_cmd == ACTC) cur_row = read_addr;
        if (read_cmd == RDC) begin
            reads++;
            for (int k = 0; k < BL; k++) begin
                dq_at[(cyc + CL + k) % 64] = word({cur_row, read_addr[7:0] + 8'(k)});
                have[(cyc + CL + k) % 64] = 1;
            end
        end
        if (read_ack) begin
            acks++;
            ack_cyc = cyc;
            ack_done = read_done;
        end
        if (read_done) begin
            checks++;
            assert (read_ack === 1'b1) else begin
                failures++;
                $error("FAIL done_without_ack got=%b want=1", read_ack);
            end
        end
        if (fifo_wr_req) begin
            words++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL fifo_extra got=%h want=no_word", fifo_wr_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (fifo_wr_data === e) else begin
                    failures++;
                    $error("FAIL fifo_data got=%h want=%h", fifo_wr_data, e);
                end
            end
        end
        read_dq = have[cyc % 64] ? dq_at[cyc % 64] : 16'($urandom);
        have[cyc % 64] = 0;
    end

    task automatic trig(input logic [19:0] a);
        sdram_addr = a;
        rd_trig = 1;
        @(negedge S_CLK);
        rd_trig = 0;
        sdram_addr = 20'($urandom);
        if (m_cnt == 0) begin
            m_ptr = a;
            m_cnt = RDW;
            for (int i = 0; i < RDW; i++) exp_q.push_back(word(a + 20'(i)));
        end
    endtask

    task automatic grant(input bit aref, input int hold, input bit tr, input logic [19:0] ta);
        int n, col, a0, r0;
        chk("req_before", 32'(read_req), 32'(m_cnt != 0));
        col = int'(m_ptr[7:0]);
        n = m_cnt / BL;
        if ((256 - col + BL - 1) / BL < n) n = (256 - col + BL - 1) / BL;
        if (aref) n = 1;
        log_q.delete();
        a0 = acks;
        r0 = reads;
        read_en = 1;
        @(negedge S_CLK);
        chk("req_drop", 32'(read_req), 0);
        if (tr) begin
            sdram_addr = ta;
            rd_trig = 1;
        end
        repeat (hold) @(negedge S_CLK);
        read_en = 0;
        rd_trig = 0;
        if (aref) begin
            for (int i = 0; i < 50 && reads == r0; i++) @(negedge S_CLK);
            aref_req = 1;
        end
        for (int i = 0; i < 200 && acks == a0; i++) @(negedge S_CLK);
        aref_req = 0;
        chk("ack_seen", 32'(acks - a0), 1);
        chk("log_len", 32'(log_q.size()), 32'(n + 2));
        if (log_q.size() == n + 2) begin
            chk("act", {log_q[0].cmd, log_q[0].addr}, {ACTC, m_ptr[19:8]});
            for (int i = 0; i < n; i++) begin
                chk("read", {log_q[i+1].cmd, log_q[i+1].addr}, {RDC, 4'h0, m_ptr[7:0] + 8'(i * BL)});
                chk("read_gap", 32'(log_q[i+1].cyc - log_q[i].cyc), i == 0 ? TRCD : BL);
            end
            chk("pre", {log_q[n+1].cmd, log_q[n+1].addr}, {PREC, 12'h400});
            chk("pre_gap", 32'(log_q[n+1].cyc - log_q[n].cyc), BL);
            chk("ack_gap", 32'(ack_cyc - log_q[n+1].cyc), W);
        end
        m_ptr = m_ptr + 20'(n * BL);
        m_cnt = m_cnt - n * BL;
        chk("done", 32'(ack_done), 32'(m_cnt == 0));
        chk("words_left", 32'(exp_q.size()), 32'(m_cnt));
        @(negedge S_CLK);
        chk("req_after", 32'(read_req), 32'(m_cnt != 0));
    endtask

    initial begin
        logic [19:0] a;
        int w0, r0, g;
        seed = 16'($urandom);
        repeat (3) @(negedge S_CLK);
        chk("rst_cmd", 32'(read_cmd), 32'(NOP));
        chk("rst_addr", 32'(read_addr), 0);
        chk("rst_outs", {read_req, read_ack, fifo_wr_req, read_done, fifo_wr_data}, 0);
        RST = 0;
        @(negedge S_CLK);
        chk("idle_req", 32'(read_req), 0);

        trig(20'h01200);
        grant(0, 0, 0, 0);

        trig(20'h003FC);
        grant(0, 0, 0, 0);
        grant(0, 0, 0, 0);

        trig(20'hFFFFC);
        grant(0, 0, 0, 0);
        grant(0, 0, 0, 0);

        trig(20'h0A000);
        grant(1, 0, 0, 0);
        grant(0, 0, 0, 0);

        trig(20'h0ABC0);
        trig(20'h55550);
        grant(0, 2, 1, 20'h12340);

        for (int t = 0; t < 6; t++) begin
            a = 20'($urandom) & 20'hFFFFC;
            if (t == 0) a[7:0] = 8'hF8;
            trig(a);
            g = 0;
            while (m_cnt != 0 && g < 8) begin
                if ($urandom_range(0, 3) == 0) grant(1, 0, 0, 0);
                else grant(0, 2 * $urandom_range(0, 1), 0, 0);
                g++;
            end
        end

        trig(20'h07700);
        r0 = reads;
        read_en = 1;
        @(negedge S_CLK);
        read_en = 0;
        for (int i = 0; i < 50 && reads == r0; i++) @(negedge S_CLK);
        repeat (2) @(negedge S_CLK);
        #2 RST = 1;
        exp_q.delete();
        m_cnt = 0;
        w0 = words;
        #1;
        chk("mid_rst_cmd", 32'(read_cmd), 32'(NOP));
        chk("mid_rst_addr", 32'(read_addr), 0);
        chk("mid_rst_outs", {read_req, read_ack, fifo_wr_req, read_done, fifo_wr_data}, 0);
        repeat (2) @(negedge S_CLK);
        RST = 0;
        repeat (20) @(negedge S_CLK);
        chk("no_fifo_after_rst", 32'(words - w0), 0);
        chk("req_after_rst", 32'(read_req), 0);

        trig(20'h00100);
        grant(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
